bin2bcd_seq: RTL
================

# bin2bcd_seq

Parametrised sequential binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm, one input bit per clock. Replaces the fixed 4-bit combinational decoder (4-bit binary to two BCD digits) with a generic BIN_W-bit to DIGITS-digit converter with a start/done handshake and an enable stall. It sits between binary datapath results and display/reporting logic.

## Interface
- BIN_W, default 8: width of binary input; legal range 1..32.
- DIGITS, default 3: number of BCD output digits. Elaboration must fail unless 10^DIGITS > 2^BIN_W - 1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- enable  input  1  global enable. Low: start is ignored and any in-progress conversion freezes.
- start  input  1  request a conversion; sampled only when enable=1 and busy=0.
- a  input  BIN_W  binary operand; captured on the accepting edge only.
- busy  output  1  high while a conversion is in its shift phase.
- done  output  1  single-cycle pulse when b holds a new result.
- b  output  4*DIGITS  packed BCD result; digit 0 in b[3:0] (units), digit i in b[4i+3:4i].

## Operation
- States: IDLE, SHIFT, DONE.
- Registers:
  - operand shift register, BIN_W bits;
  - BCD accumulator, 4*DIGITS bits;
  - bit counter, clog2(BIN_W+1) bits;
  - result register b.
- IDLE: on an edge with enable=1 and start=1:
  - load operand <= a and accumulator <= 0;
  - set counter = 0 and go to SHIFT.
- SHIFT, on each edge with enable=1:
  - every accumulator digit >= 5 gets +3 (all digits corrected in parallel from the pre-shift value);
  - {accumulator, operand} shifts left by 1; the operand MSB enters accumulator bit 0;
  - counter increments.
- SHIFT exit: after the BIN_W-th shift, b <= final accumulator, done <= 1, go to DONE.
- DONE lasts one cycle; done=1 and returns to 0 on the next edge.
  - With start=1 and enable=1 in DONE: the new conversion is accepted on that edge and the state goes to SHIFT (back-to-back).
  - Otherwise the state goes to IDLE.
- start with busy=1 is ignored. It is not queued. The running conversion is unaffected.
- enable=0 in SHIFT: all registers hold (stall). enable=0 in DONE: done still drops after one cycle and the state goes to IDLE.
- b holds the last result until the next DONE. b is not cleared by a new start.
- No add-3 is applied to the digit receiving the final shift beyond the BIN_W iterations. The result is exact for all 0..2^BIN_W-1.
- Reset (rst_n=0 at an edge) has priority over everything:
  - state=IDLE, busy=0, done=0, b=0;
  - accumulator, operand and counter = 0.
  - A conversion in progress when reset is asserted is discarded and produces no done.

## Timing
- Start accepted at edge k, with enable held high:
  - busy=1 from after edge k through edge k+BIN_W;
  - b valid and done=1 from after edge k+BIN_W, for one cycle;
  - busy=0 from after edge k+BIN_W.
- Latency from the accepting edge to done: BIN_W cycles. Maximum throughput: one result per BIN_W+1 cycles.
- Each cycle with enable=0 during SHIFT adds exactly one cycle of latency.
- Outputs are registered. There is no combinational path from start, a or enable to any output.
- busy and done are never high in the same cycle.

## Test plan
- Reset, then BIN_W=8, DIGITS=3, a=8'd255, start pulse -> busy high for 8 cycles; done pulses 8 cycles after the accepting edge with b=12'h255; b holds 12'h255 for 20 idle cycles.
- Sweep a=0..255 with back-to-back starts asserted in DONE -> every b equals the reference BCD of a (e.g. 0→12'h000, 9→12'h009, 10→12'h010, 99→12'h099, 100→12'h100); one done per 9 cycles.
- Instance BIN_W=4, DIGITS=2, sweep a=0..15 -> b matches the legacy decoder map (a=10→8'h10, a=15→8'h15, a=9→8'h09); latency 4.
- Start a=200, then pulse start with a=7 at cycle 3 of SHIFT -> second request ignored; done once with b=12'h200.
- Start a=123, drop enable for 5 cycles mid-SHIFT -> done arrives 13 cycles after the accepting edge with b=12'h123; start during enable=0 in IDLE -> ignored, no done.
- Start a=255, assert rst_n=0 at cycle 4 of SHIFT for one cycle -> busy=0, done=0, b=0 after the reset edge; no done follows. A new start a=42 then gives b=12'h042.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-add-3 / double dabble), one operand bit per clock.
// Latency: BIN_W cycles from the accepting edge to done, plus one cycle per stalled (enable=0) SHIFT cycle;
//          throughput one result per BIN_W+1 cycles with back-to-back starts issued while done is high.
// Backpressure: start is only sampled when enable=1 and busy=0; requests while busy are dropped, not queued.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   enable  global enable; low freezes a conversion in progress and masks start
//   start   conversion request
//   a       BIN_W-bit binary operand, captured on the accepting edge
//   busy    high during the shift phase
//   done    one-cycle pulse when b carries a new result
//   b       packed BCD result, digit 0 (units) in b[3:0]
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                start,
    input  logic [BIN_W-1:0]    a,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] b
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // True when DIGITS decimal digits can represent every BIN_W-bit value.
    // 10^11 already exceeds 2^32, so the power loop is capped there.
    function automatic bit digits_fit(input int bw, input int dg);
        longint p10;
        longint maxv;
        p10 = 1;
        for (int i = 0; i < dg && i < 11; i++) begin
            p10 = p10 * 10;
        end
        maxv = (longint'(1) << bw) - 1;
        return p10 > maxv;
    endfunction

    generate
        if (BIN_W < 1 || BIN_W > 32) begin : g_bad_width
            $error("bin2bcd_seq: BIN_W must be in 1..32");
        end
        if (DIGITS < 1 || !digits_fit(BIN_W, DIGITS)) begin : g_bad_digits
            $error("bin2bcd_seq: DIGITS too small for BIN_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [BIN_W-1:0]   opnd;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   b_q;

    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_shift;
    logic [BIN_W-1:0]   opnd_shift;
    logic               last_shift;
    logic               accept;

    // A new request can be taken from IDLE, or from DONE for back-to-back use.
    assign accept     = enable && start && (state == ST_IDLE || state == ST_DONE);
    assign last_shift = (cnt == CNT_W'(BIN_W - 1));

    // Add-3 correction on every digit, all evaluated from the pre-shift value.
    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
    end

    // The top accumulator bit is always zero before the final shift because
    // the digit count covers the full operand range, so dropping it is safe.
    assign acc_shift  = {acc_adj[ACC_W-2:0], opnd[BIN_W-1]};
    assign opnd_shift = opnd << 1;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (enable && start) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (enable && last_shift) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // done always drops after one cycle, even with enable low.
                if (enable && start) begin
                    state_nxt = ST_SHIFT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs decode directly from registered state, so no input reaches them combinationally.
    always_comb begin
        busy = (state == ST_SHIFT);
        done = (state == ST_DONE);
        b    = b_q;
    end

    // Datapath: operand, accumulator, bit counter and result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opnd <= '0;
            acc  <= '0;
            cnt  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            opnd <= a;
            acc  <= '0;
            cnt  <= '0;
        end else if (state == ST_SHIFT && enable) begin
            opnd <= opnd_shift;
            acc  <= acc_shift;
            cnt  <= cnt + CNT_W'(1);
            if (last_shift) begin
                b_q <= acc_shift;
            end
        end
    end

endmodule
